// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: angle constants, arctangent table, gain compensation and FSM states.
// Angles are signed radians scaled by 2^(aw-3); the table is held at 32-bit scale and rescaled.
package cordic_pkg;

  localparam int          ITER_W          = 5;
  localparam logic [15:0] CORDIC_GAIN_INV = 16'h26DD;
  localparam logic [63:0] ANGLE_PI        = 64'h6487ED51;
  localparam logic [63:0] ANGLE_PI_2      = 64'h3243F6A9;

  typedef enum logic [2:0] {S_IDLE, S_FOLD, S_ITER, S_COMP, S_DONE} cordic_state_t;

  function automatic logic [63:0] scale_angle(input logic [63:0] v, input int aw);
    if (aw >= 32) return v << (aw - 32);
    else          return v >> (32 - aw);
  endfunction

  // atan(2^-i) * 2^29, rounded to nearest
  function automatic logic [63:0] atan_tab(input logic [ITER_W-1:0] i, input int aw);
    logic [31:0] t;
    case (i)
      5'd0:  t = 32'h1921FB54;
      5'd1:  t = 32'h0ED63383;
      5'd2:  t = 32'h07D6DD7E;
      5'd3:  t = 32'h03FAB753;
      5'd4:  t = 32'h01FF55BB;
      5'd5:  t = 32'h00FFEAAE;
      5'd6:  t = 32'h007FFD55;
      5'd7:  t = 32'h003FFFAB;
      5'd8:  t = 32'h001FFFF5;
      5'd9:  t = 32'h000FFFFF;
      5'd10: t = 32'h00080000;
      5'd11: t = 32'h00040000;
      5'd12: t = 32'h00020000;
      5'd13: t = 32'h00010000;
      5'd14: t = 32'h00008000;
      5'd15: t = 32'h00004000;
      5'd16: t = 32'h00002000;
      5'd17: t = 32'h00001000;
      5'd18: t = 32'h00000800;
      5'd19: t = 32'h00000400;
      5'd20: t = 32'h00000200;
      5'd21: t = 32'h00000100;
      5'd22: t = 32'h00000080;
      5'd23: t = 32'h00000040;
      5'd24: t = 32'h00000020;
      5'd25: t = 32'h00000010;
      5'd26: t = 32'h00000008;
      5'd27: t = 32'h00000004;
      5'd28: t = 32'h00000002;
      default: t = 32'h00000001;
    endcase
    return scale_angle({32'd0, t}, aw);
  endfunction

endpackage

// File: rtl/cordic_vectoring_if.sv
// Start/done request and result bundle for the vectoring CORDIC.
interface cordic_vectoring_if #(
  parameter int WIDTH       = 16,
  parameter int ANGLE_WIDTH = 32
);
  logic                          start;
  logic signed [WIDTH-1:0]       x_in;
  logic signed [WIDTH-1:0]       y_in;
  logic        [WIDTH-1:0]       magnitude;
  logic signed [ANGLE_WIDTH-1:0] angle;
  logic                          busy;
  logic                          done;

  modport master (output start, x_in, y_in, input  magnitude, angle, busy, done);
  modport slave  (input  start, x_in, y_in, output magnitude, angle, busy, done);
endinterface

// File: rtl/cordic_vec_stage.sv
// One vectoring micro-rotation: drives y toward zero and accumulates the rotated angle in z.
module cordic_vec_stage
  import cordic_pkg::*;
#(
  parameter int XW = 18,
  parameter int AW = 32
) (
  input  logic signed [XW-1:0]     x,
  input  logic signed [XW-1:0]     y,
  input  logic signed [AW-1:0]     z,
  input  logic        [ITER_W-1:0] i,
  output logic signed [XW-1:0]     x_n,
  output logic signed [XW-1:0]     y_n,
  output logic signed [AW-1:0]     z_n
);
  logic signed [XW-1:0] xs, ys;
  logic signed [AW-1:0] a;

  assign xs = x >>> i;
  assign ys = y >>> i;
  assign a  = signed'(AW'(atan_tab(i, AW)));

  always_comb begin
    if (!y[XW-1]) begin
      x_n = x + ys;
      y_n = y - xs;
      z_n = z + a;
    end else begin
      x_n = x - ys;
      y_n = y + xs;
      z_n = z - a;
    end
  end
endmodule

// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> gain-compensated magnitude and atan2(y, x).
// One micro-rotation per clock, bracketed by a quadrant fold and a gain-compensation cycle.
module cordic_vectoring
  import cordic_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int ITERATIONS  = 15,
  parameter int ANGLE_WIDTH = 32
) (
  input logic               clock,
  input logic               reset,
  cordic_vectoring_if.slave bus
);
  localparam int XW = WIDTH + 2;
  localparam int PW = XW + 17;
  localparam logic signed [ANGLE_WIDTH-1:0] PI_A   = ANGLE_WIDTH'(scale_angle(ANGLE_PI, ANGLE_WIDTH));
  localparam logic signed [ANGLE_WIDTH-1:0] PI_2_A = ANGLE_WIDTH'(scale_angle(ANGLE_PI_2, ANGLE_WIDTH));
  localparam logic [ITER_W-1:0]             LAST   = ITER_W'(ITERATIONS - 1);

  cordic_state_t                 state;
  logic signed [XW-1:0]          x_r, y_r, x_n, y_n;
  logic signed [ANGLE_WIDTH-1:0] z_r, z_n, angle_q;
  logic        [ITER_W-1:0]      iter;
  logic                          zero_vec, busy_q, done_q;
  logic        [WIDTH-1:0]       mag_q;
  logic signed [PW-1:0]          kx, prod;

  cordic_vec_stage #(.XW(XW), .AW(ANGLE_WIDTH)) u_stage (
    .x(x_r), .y(y_r), .z(z_r), .i(iter), .x_n(x_n), .y_n(y_n), .z_n(z_n)
  );

  assign kx   = PW'(signed'({1'b0, CORDIC_GAIN_INV}));
  assign prod = PW'(x_r) * kx;

  assign bus.magnitude = mag_q;
  assign bus.angle     = angle_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      x_r      <= '0;
      y_r      <= '0;
      z_r      <= '0;
      iter     <= '0;
      zero_vec <= 1'b0;
      mag_q    <= '0;
      angle_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            x_r      <= {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
            y_r      <= {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
            zero_vec <= (bus.x_in == '0) && (bus.y_in == '0);
            busy_q   <= 1'b1;
            state    <= S_FOLD;
          end
        end
        S_FOLD: begin
          // Left half-plane is rotated by +/-pi/2 so the iterations only cover (-pi/2, pi/2)
          if (x_r[XW-1]) begin
            if (!y_r[XW-1]) begin
              x_r <= y_r;
              y_r <= -x_r;
              z_r <= PI_2_A;
            end else begin
              x_r <= -y_r;
              y_r <= x_r;
              z_r <= -PI_2_A;
            end
          end else begin
            z_r <= '0;
          end
          iter  <= '0;
          state <= S_ITER;
        end
        S_ITER: begin
          x_r <= x_n;
          y_r <= y_n;
          z_r <= z_n;
          if (iter == LAST) state <= S_COMP;
          else              iter  <= iter + 1'b1;
        end
        S_COMP: begin
          mag_q <= WIDTH'(prod >>> (WIDTH - 2));
          // Residual overshoot past pi is clamped so the x<0, y=0 case stays at +pi
          if (zero_vec)         angle_q <= '0;
          else if (z_r > PI_A)  angle_q <= PI_A;
          else if (z_r <= -PI_A) angle_q <= -PI_A + 1'b1;
          else                  angle_q <= z_r;
          state <= S_DONE;
        end
        S_DONE: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cordic_vectoring.sv
// Directed-vector bench for cordic_vectoring with a queue scoreboard checked by a done monitor.
module tb_cordic_vectoring;
  localparam int WIDTH       = 16;
  localparam int ITERATIONS  = 15;
  localparam int ANGLE_WIDTH = 32;

  typedef struct {
    string  name;
    longint mag;
    longint mtol;
    longint ang;
    longint atol;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  cordic_vectoring_if #(.WIDTH(WIDTH), .ANGLE_WIDTH(ANGLE_WIDTH)) bus ();

  cordic_vectoring #(.WIDTH(WIDTH), .ITERATIONS(ITERATIONS), .ANGLE_WIDTH(ANGLE_WIDTH)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input longint act, input longint exp, input longint tol);
    compared++;
    if (act - exp > tol || exp - act > tol) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) tol %0d", name, act, act, exp, exp, tol);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(posedge clock) begin
    #1;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_done: got done with empty scoreboard, want no done");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk({e.name, "_mag"}, longint'(bus.magnitude), e.mag, e.mtol);
        chk({e.name, "_ang"}, longint'(bus.angle), e.ang, e.atol);
      end
    end
  end

  task automatic issue(input string name, input logic [15:0] x, input logic [15:0] y,
                       input longint mag, input longint mtol, input longint ang, input longint atol,
                       input bit repulse);
    int lat;
    bit got;
    exp_t e;
    e.name = name; e.mag = mag; e.mtol = mtol; e.ang = ang; e.atol = atol;
    sb.push_back(e);
    @(negedge clock);
    bus.x_in  = x;
    bus.y_in  = y;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    lat = 0;
    got = 0;
    while (!got && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
      if (bus.done === 1'b1) got = 1;
      else if (repulse && (lat == 3 || lat == 10)) begin
        bus.start = 1'b1;
        bus.x_in  = 16'hC000;
        bus.y_in  = 16'h1234;
      end else bus.start = 1'b0;
    end
    bus.start = 1'b0;
    if (!got) begin
      compared++;
      mismatched++;
      $display("FAIL %s_timeout: got no done in 40 cycles, want done", name);
    end else begin
      chk({name, "_latency"}, lat, ITERATIONS + 3, 0);
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.x_in  = '0;
    bus.y_in  = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", bus.busy, 0, 0);
    chk("rst_done", bus.done, 0, 0);
    chk("rst_mag",  bus.magnitude, 0, 0);
    chk("rst_ang",  bus.angle, 0, 0);
    @(negedge clock);
    reset = 1'b0;

    issue("unit_x",  16'h4000, 16'h0000, 64'h4000, 19, 0,             64'h10000, 0);
    issue("v_06_08", 16'h2666, 16'h3333, 64'h4000, 19, 64'h1DAC6705,  64'h10000, 0);
    issue("neg_x",   16'hC000, 16'h0000, 64'h4000, 19, 64'h6487ED51,  64'h10000, 0);
    issue("q3",      16'hC000, 16'hC000, 64'h5A82, 19, -64'h4B65F1FD, 64'h10000, 0);
    issue("zero",    16'h0000, 16'h0000, 0,        0,  0,             0,         0);
    issue("corner",  16'h8000, 16'h8000, 64'hB505, 19, -64'h4B65F1FD, 64'h10000, 0);
    issue("repulse", 16'h4000, 16'h4000, 64'h5A82, 19, 64'h1921FB54,  64'h10000, 1);
    repeat (3) @(posedge clock);

    // Abort an operation mid-iteration with an asynchronous reset
    @(negedge clock);
    bus.x_in  = 16'h2000;
    bus.y_in  = 16'h6000;
    bus.start = 1'b1;
    @(posedge clock);
    #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_busy", bus.busy, 0, 0);
    chk("abort_done", bus.done, 0, 0);
    chk("abort_mag",  bus.magnitude, 0, 0);
    chk("abort_ang",  bus.angle, 0, 0);
    @(negedge clock);
    reset = 1'b0;
    repeat (25) @(posedge clock);

    issue("post_rst", 16'h0000, 16'h4000, 64'h4000, 19, 64'h3243F6A9, 64'h10000, 0);
    repeat (25) @(posedge clock);
    #2;
    chk("sb_empty", sb.size(), 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end
endmodule
